frac_div_sched: RTL and testbench
=================================

FRAC_DIV_SCHED -- requirements
Module: frac_div_sched

Interface
REQ-001 SHALL have parameter W, default 8, the width of the integer, numerator and denominator fields.
REQ-002 SHALL have port clk_in, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: 1 runs the divider, 0 stops it gracefully.
REQ-005 SHALL have port cfg_valid, input, 1 bit, a configuration offer.
REQ-006 SHALL have port cfg_ready, output, 1 bit: the shadow register is empty.
REQ-007 SHALL have ports cfg_int, cfg_num and cfg_den, each input, W bits: integer part N, numerator and denominator.
REQ-008 SHALL have port cfg_err, output, 1 bit, a one-cycle pulse on a rejected configuration.
REQ-009 SHALL have port clk_out, output, 1 bit, the registered divided clock.
REQ-010 SHALL have port period_start, output, 1 bit, high in the first cycle of every output period.
REQ-011 SHALL have port sel_long, output, 1 bit, high while the current period is N+1 cycles.
REQ-012 SHALL have port active, output, 1 bit, high in RUN.

Function
REQ-013 SHALL implement states IDLE and RUN.
- IDLE->RUN: on enable=1.
- RUN->IDLE: on the last cycle of a period with enable=0.
REQ-014 SHALL make every period P = N (short) or N+1 (long) cycles; phase counter runs 0..P-1 and then wraps to 0.
REQ-015 SHALL set clk_out=1 when phase < P>>1, else 0 (e.g. P=3 gives 1,0,0).
REQ-016 SHALL make the long/short decision once per period at phase 0, as a Bresenham step on acc (W+1 bits):
- if acc+num >= den: long period, acc <= acc+num-den;
- else: short period, acc <= acc+num.
REQ-017 SHALL thereby produce exactly num long periods in every den consecutive periods.
REQ-018 SHALL accept a configuration when cfg_valid&&cfg_ready, capture it into the shadow register, and drop cfg_ready the following cycle.
REQ-019 SHALL reject a configuration with cfg_int<2, cfg_den==0 or cfg_num>=cfg_den: cfg_err=1 the next cycle, shadow unchanged, cfg_ready stays 1.
REQ-020 SHALL apply a pending shadow at the next period boundary (phase wrap), or immediately in IDLE.
- On apply: acc cleared to 0, cfg_ready raised the same cycle.
REQ-021 SHALL never alter the length of a period already in progress.
REQ-022 SHALL, on RUN entry, start at phase 0 with period_start=1 in the first RUN cycle.
REQ-023 SHALL, with enable=0 in RUN, complete the current period, then enter IDLE with clk_out=0.
REQ-024 SHALL, with enable re-asserted during the final period, not stop; a period boundary with enable=1 continues seamlessly.
REQ-025 SHALL let an apply on the same cycle as a RUN->IDLE transition take effect; the next RUN uses the new configuration.

Reset
REQ-026 SHALL, on rst=1, asynchronously force:
- state IDLE, acc=0, phase=0;
- active config N=2, num=0, den=1;
- shadow empty, cfg_ready=1;
- clk_out, period_start, sel_long, cfg_err, active all 0.
REQ-027 SHALL discard any configuration in flight on a mid-operation reset.
REQ-028 SHALL resume only on enable after rst deasserts.

Structure
REQ-029 SHALL place W, the state encoding and the reset config constants in shared package frac_div_pkg.
REQ-030 SHALL isolate the Bresenham decision and accumulator in sub-module frac_div_accum: inputs num, den, step, clear; outputs long_sel.

Verification
REQ-031 SHALL cover reset defaults: enable=1 without a configuration -> period 2, clk_out 1,0 repeating, sel_long=0.
REQ-032 SHALL cover N=3, num=1, den=2 -> periods 3,4,3,4; 7 cycles per 2 periods; sel_long 0,1 alternating.
REQ-033 SHALL cover N=4, num=2, den=3 -> periods 4,5,5 repeating; 14 cycles per 3 periods.
REQ-034 SHALL cover num=3, den=3 offered -> cfg_err pulse and unchanged output.
REQ-035 SHALL cover a mid-period reconfiguration (3,1,2)->(5,0,1) -> current period completes, then period 5; cfg_ready returns to 1 at the boundary.
REQ-036 SHALL cover enable dropped mid-period -> period finishes, then active=0 and clk_out=0.
REQ-037 SHALL cover rst pulsed mid-RUN -> all REQ-026 values within the same cycle.

Source files
------------

// File: rtl/frac_div_pkg.sv
// Shared constants for the fractional clock divider: default width,
// scheduler state encoding and the configuration loaded at reset.
package frac_div_pkg;

    localparam int unsigned FD_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fd_state_t;

    localparam int unsigned RST_N   = 2;
    localparam int unsigned RST_NUM = 0;
    localparam int unsigned RST_DEN = 1;

endpackage

// File: rtl/frac_div_accum.sv
// Bresenham error accumulator: decides long/short for each period and
// keeps the running remainder.
module frac_div_accum
    import frac_div_pkg::*;
#(
    parameter int unsigned W = FD_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    input  logic         step,
    input  logic         clear,
    output logic         long_sel
);

    logic [W:0] acc_q;
    logic [W:0] acc_d;
    logic [W:0] acc_eff;
    logic [W:0] sum;

    // clear and step together start a fresh sequence with this step's decision
    always_comb begin
        acc_eff  = clear ? '0 : acc_q;
        sum      = acc_eff + {1'b0, num};
        long_sel = (sum >= {1'b0, den});
        acc_d    = acc_q;
        if (step) begin
            acc_d = long_sel ? (sum - {1'b0, den}) : sum;
        end else if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frac_div_sched.sv
// Fractional clock divider: emits periods of N or N+1 cycles so that num of
// every den periods are long; configuration is double-buffered via a shadow.
module frac_div_sched
    import frac_div_pkg::*;
#(
    parameter int unsigned W = FD_W
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         enable,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_int,
    input  logic [W-1:0] cfg_num,
    input  logic [W-1:0] cfg_den,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         period_start,
    output logic         sel_long,
    output logic         active
);

    localparam logic [W:0] ONE = (W+1)'(1);

    fd_state_t    state_q;
    logic [W:0]   phase_q;
    logic [W:0]   plen_q;
    logic [W-1:0] n_q, num_q, den_q;
    logic [W-1:0] sh_n_q, sh_num_q, sh_den_q;
    logic         sh_full_q;
    logic         cfg_err_q, clk_out_q, period_start_q, sel_long_q, active_q;

    logic         last, apply, start, accept, cfg_bad, long_sel;
    logic [W-1:0] eff_n, eff_num, eff_den;
    logic [W:0]   plen_new;

    // a pending shadow replaces the active config right at the edge where the
    // next period is decided, so that decision already uses the new values
    always_comb begin
        last     = (state_q == ST_RUN) && (phase_q == plen_q - ONE);
        apply    = sh_full_q && ((state_q == ST_IDLE) || last);
        start    = enable && ((state_q == ST_IDLE) || last);
        eff_n    = apply ? sh_n_q   : n_q;
        eff_num  = apply ? sh_num_q : num_q;
        eff_den  = apply ? sh_den_q : den_q;
        plen_new = {1'b0, eff_n} + {{W{1'b0}}, long_sel};
        accept   = cfg_valid && !sh_full_q;
        cfg_bad  = (cfg_int < W'(2)) || (cfg_den == '0) || (cfg_num >= cfg_den);
    end

    frac_div_accum #(.W(W)) u_accum (
        .clk_in   (clk_in),
        .rst      (rst),
        .num      (eff_num),
        .den      (eff_den),
        .step     (start),
        .clear    (apply),
        .long_sel (long_sel)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            plen_q         <= (W+1)'(RST_N);
            n_q            <= W'(RST_N);
            num_q          <= W'(RST_NUM);
            den_q          <= W'(RST_DEN);
            sh_n_q         <= '0;
            sh_num_q       <= '0;
            sh_den_q       <= '0;
            sh_full_q      <= 1'b0;
            cfg_err_q      <= 1'b0;
            clk_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            sel_long_q     <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            cfg_err_q <= accept && cfg_bad;
            if (accept && !cfg_bad) begin
                sh_n_q    <= cfg_int;
                sh_num_q  <= cfg_num;
                sh_den_q  <= cfg_den;
                sh_full_q <= 1'b1;
            end
            if (apply) begin
                n_q       <= sh_n_q;
                num_q     <= sh_num_q;
                den_q     <= sh_den_q;
                sh_full_q <= 1'b0;
            end
            if (start) begin
                state_q        <= ST_RUN;
                phase_q        <= '0;
                plen_q         <= plen_new;
                clk_out_q      <= (plen_new >> 1) != '0;
                period_start_q <= 1'b1;
                sel_long_q     <= long_sel;
                active_q       <= 1'b1;
            end else if (last) begin
                state_q        <= ST_IDLE;
                phase_q        <= '0;
                clk_out_q      <= 1'b0;
                period_start_q <= 1'b0;
                sel_long_q     <= 1'b0;
                active_q       <= 1'b0;
            end else if (state_q == ST_RUN) begin
                phase_q        <= phase_q + ONE;
                clk_out_q      <= (phase_q + ONE) < (plen_q >> 1);
                period_start_q <= 1'b0;
            end
        end
    end

    assign cfg_ready    = !sh_full_q;
    assign cfg_err      = cfg_err_q;
    assign clk_out      = clk_out_q;
    assign period_start = period_start_q;
    assign sel_long     = sel_long_q;
    assign active       = active_q;

endmodule

// File: tb/tb_frac_div_sched.sv
// Bench for frac_div_sched: per-cycle comparison against a period-level
// Bresenham model plus directed period-length checks.
module tb_frac_div_sched;

    localparam int unsigned W = 8;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         enable;
    logic         cfg_valid;
    logic [W-1:0] cfg_int, cfg_num, cfg_den;
    logic         cfg_ready, cfg_err, clk_out, period_start, sel_long, active;

    int vectors     = 0;
    int miscompares = 0;

    // model state: period index since last apply gives long/short in closed form
    bit m_run, m_long, m_shv, m_err;
    int m_N, m_num, m_den, s_N, s_num, s_den, m_ph, m_P, m_k;

    int plens[$];
    int pcnt;
    int exp_len;

    always #5 clk_in = ~clk_in;

    frac_div_sched #(.W(W)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_int      (cfg_int),
        .cfg_num      (cfg_num),
        .cfg_den      (cfg_den),
        .cfg_err      (cfg_err),
        .clk_out      (clk_out),
        .period_start (period_start),
        .sel_long     (sel_long),
        .active       (active)
    );

    function automatic int bres(input int k, input int num, input int den);
        longint a, b;
        a = (longint'(k) + 1) * num / den;
        b = longint'(k) * num / den;
        return int'(a - b);
    endfunction

    function automatic int plen_at(input int i);
        if (i < plens.size()) return plens[i];
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_long = 0; m_shv = 0; m_err = 0;
        m_N = 2; m_num = 0; m_den = 1; m_ph = 0; m_P = 2; m_k = 0;
        s_N = 0; s_num = 0; s_den = 0;
    endtask

    task automatic model_edge();
        bit bnd, oldv;
        if (rst) begin
            model_reset();
            return;
        end
        bnd   = !m_run || (m_ph == m_P - 1);
        oldv  = m_shv;
        m_err = 0;
        if (bnd && oldv) begin
            m_N = s_N; m_num = s_num; m_den = s_den; m_shv = 0; m_k = 0;
        end
        if (cfg_valid && !oldv) begin
            if (int'(cfg_int) < 2 || cfg_den == 0 || cfg_num >= cfg_den) m_err = 1;
            else begin
                s_N = int'(cfg_int); s_num = int'(cfg_num); s_den = int'(cfg_den);
                m_shv = 1;
            end
        end
        if (bnd) begin
            if (enable) begin
                m_run  = 1;
                m_ph   = 0;
                m_long = bres(m_k, m_num, m_den) != 0;
                m_P    = m_N + (m_long ? 1 : 0);
                m_k++;
            end else begin
                m_run = 0;
                m_ph  = 0;
            end
        end else begin
            m_ph++;
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        chk("active",       32'(active),       32'(m_run));
        chk("clk_out",      32'(clk_out),      32'(m_run && (m_ph < m_P / 2)));
        chk("period_start", 32'(period_start), 32'(m_run && (m_ph == 0)));
        chk("sel_long",     32'(sel_long),     32'(m_run && m_long));
        chk("cfg_ready",    32'(cfg_ready),    32'(!m_shv));
        chk("cfg_err",      32'(cfg_err),      32'(m_err));
        if (period_start === 1'b1) begin
            if (pcnt > 0) plens.push_back(pcnt);
            pcnt = 1;
        end else if (active === 1'b1) begin
            pcnt++;
        end else begin
            if (pcnt > 0) plens.push_back(pcnt);
            pcnt = 0;
        end
    endtask

    task automatic offer(input int n, input int nu, input int d);
        cfg_valid = 1'b1;
        cfg_int   = W'(n);
        cfg_num   = W'(nu);
        cfg_den   = W'(d);
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_int = '0; cfg_num = '0; cfg_den = '0;
        pcnt = 0;
        model_reset();
        repeat (2) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // default configuration: period 2
        enable = 1'b1;
        repeat (10) cyc();
        chk("dflt_p0", plen_at(0), 2);
        chk("dflt_p1", plen_at(1), 2);
        chk("dflt_p2", plen_at(2), 2);

        // 3 + 1/2 -> 3,4,3,4
        offer(3, 1, 2);
        for (int i = 0; i < 10 && m_shv; i++) cyc();
        plens.delete();
        repeat (20) cyc();
        chk("c312_p0", plen_at(0), 3);
        chk("c312_p1", plen_at(1), 4);
        chk("c312_p2", plen_at(2), 3);
        chk("c312_p3", plen_at(3), 4);

        // num == den is rejected, output continues unchanged
        offer(3, 3, 3);
        chk("rej_err", 32'(cfg_err), 1);
        chk("rej_ready", 32'(cfg_ready), 1);
        plens.delete();
        repeat (14) cyc();
        chk("rej_pair", plen_at(1) + plen_at(2), 7);

        // mid-period switch to integer division by 5
        for (int i = 0; i < 10 && m_ph != 1; i++) cyc();
        exp_len = m_P;
        offer(5, 0, 1);
        plens.delete();
        for (int i = 0; i < 10 && m_shv; i++) cyc();
        chk("mid_keep_len", plen_at(0), exp_len);
        chk("mid_ready_at_bnd", 32'(cfg_ready), 1);
        chk("mid_start_at_bnd", 32'(period_start), 1);
        plens.delete();
        repeat (16) cyc();
        chk("c501_p0", plen_at(0), 5);
        chk("c501_p1", plen_at(1), 5);

        // 4 + 2/3 -> 4,5,5
        offer(4, 2, 3);
        for (int i = 0; i < 10 && m_shv; i++) cyc();
        plens.delete();
        repeat (30) cyc();
        chk("c423_p0", plen_at(0), 4);
        chk("c423_p1", plen_at(1), 5);
        chk("c423_p2", plen_at(2), 5);
        chk("c423_sum", plen_at(3) + plen_at(4) + plen_at(5), 14);

        // graceful stop mid-period
        for (int i = 0; i < 10 && m_ph != 1; i++) cyc();
        exp_len = m_P;
        enable = 1'b0;
        plens.delete();
        for (int i = 0; i < 10 && m_run; i++) cyc();
        chk("stop_len", plen_at(0), exp_len);
        chk("stop_active", 32'(active), 0);
        chk("stop_clk", 32'(clk_out), 0);

        // apply coinciding with the stop edge is kept for the next run
        enable = 1'b1;
        for (int i = 0; i < 10 && !(m_run && m_ph == 0); i++) cyc();
        offer(3, 1, 2);
        for (int i = 0; i < 10 && m_ph != m_P - 1; i++) cyc();
        enable = 1'b0;
        cyc();
        chk("stopapply_active", 32'(active), 0);
        chk("stopapply_ready", 32'(cfg_ready), 1);
        repeat (2) cyc();
        enable = 1'b1;
        plens.delete();
        repeat (15) cyc();
        chk("restart_p0", plen_at(0), 3);
        chk("restart_p1", plen_at(1), 4);

        // asynchronous reset mid-period with a config pending
        for (int i = 0; i < 10 && m_ph != 0; i++) cyc();
        offer(6, 1, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_active", 32'(active), 0);
        chk("arst_clk", 32'(clk_out), 0);
        chk("arst_start", 32'(period_start), 0);
        chk("arst_long", 32'(sel_long), 0);
        chk("arst_err", 32'(cfg_err), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        cyc();
        enable = 1'b0;
        rst = 1'b0;
        repeat (2) cyc();
        chk("arst_idle", 32'(active), 0);
        enable = 1'b1;
        plens.delete();
        repeat (8) cyc();
        chk("arst_dflt_p0", plen_at(0), 2);
        chk("arst_dflt_p1", plen_at(1), 2);

        // randomized enable toggling and configuration offers
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 6) == 0);
            cfg_int   = W'($urandom_range(0, 6));
            cfg_num   = W'($urandom_range(0, 4));
            cfg_den   = W'($urandom_range(0, 4));
            cyc();
        end
        cfg_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
